// File: rtl/iiitb_cg_ctrl.sv
// Clock-gating controller: per-domain idle detection drops ICG enables, and a
// round-robin arbiter re-enables at most one gated domain per cycle.
module iiitb_cg_ctrl #(
    parameter int N_DOM    = 4,
    parameter int IDLE_CYC = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_DOM-1:0]             busy,
    input  logic [N_DOM-1:0]             req,
    input  logic                         cg_bypass,
    output logic [N_DOM-1:0]             cg_en,
    output logic [N_DOM-1:0]             ready,
    output logic [$clog2(N_DOM+1)-1:0]   n_off
);

    localparam int MAX_CYC = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int PTR_W   = $clog2(N_DOM);
    localparam int OFF_W   = $clog2(N_DOM + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

    typedef enum logic [1:0] {ST_RUN, ST_IDLE_CNT, ST_OFF, ST_WAKE} dom_state_t;

    logic [N_DOM-1:0] pending;
    logic [N_DOM-1:0] grant;
    logic [N_DOM-1:0] off_next;
    logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [OFF_W-1:0] n_off_reg, n_off_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_DOM; gi++) begin : g_dom
            dom_state_t       state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             cg_en_reg, ready_reg;
            logic             idle;

            assign idle         = !busy[gi] && !req[gi] && !cg_bypass;
            assign pending[gi]  = (state_reg == ST_OFF) && (busy[gi] || req[gi] || cg_bypass);
            assign off_next[gi] = (state_next == ST_OFF);
            assign cg_en[gi]    = cg_en_reg;
            assign ready[gi]    = ready_reg;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_RUN: begin
                        if (idle) begin
                            if (IDLE_CYC == 1) begin
                                state_next = ST_OFF;
                                cnt_next   = '0;
                            end else begin
                                state_next = ST_IDLE_CNT;
                                cnt_next   = CNT_W'(1);
                            end
                        end
                    end
                    ST_IDLE_CNT: begin
                        if (!idle) begin
                            state_next = ST_RUN;
                            cnt_next   = '0;
                        end else if (cnt_reg == IDLE_LAST) begin
                            state_next = ST_OFF;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    ST_OFF: begin
                        if (grant[gi]) begin
                            state_next = ST_WAKE;
                            cnt_next   = '0;
                        end
                    end
                    ST_WAKE: begin
                        // Inputs are ignored here so the enable is held for the full settle time.
                        if (cnt_reg == WAKE_LAST) begin
                            state_next = ST_RUN;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end
                endcase
            end

            // Outputs are registered from the next state so the ICG sees a glitch-free enable.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                    cg_en_reg <= 1'b1;
                    ready_reg <= 1'b1;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    cg_en_reg <= (state_next != ST_OFF);
                    ready_reg <= (state_next == ST_RUN) || (state_next == ST_IDLE_CNT);
                end
            end
        end
    endgenerate

    // Round-robin search from rr_ptr; first pending OFF domain wins.
    always_comb begin
        logic             found;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] sel;
        grant       = '0;
        rr_ptr_next = rr_ptr_reg;
        found       = 1'b0;
        sum         = '0;
        sel         = '0;
        for (int k = 0; k < N_DOM; k++) begin
            sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_DOM))
                sum = sum - (PTR_W+1)'(N_DOM);
            sel = sum[PTR_W-1:0];
            if (!found && pending[sel]) begin
                found       = 1'b1;
                grant[sel]  = 1'b1;
                rr_ptr_next = (sel == PTR_W'(N_DOM - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_comb begin
        n_off_next = '0;
        for (int k = 0; k < N_DOM; k++)
            n_off_next = n_off_next + OFF_W'(off_next[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            n_off_reg  <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            n_off_reg  <= n_off_next;
        end
    end

    assign n_off = n_off_reg;

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// Scoreboard bench for iiitb_cg_ctrl: the driver queues hand-computed
// post-edge expectations, the monitor pops and compares them mid-cycle.
module tb_iiitb_cg_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] busy;
    logic [3:0] req;
    logic       cg_bypass;
    logic [3:0] cg_en;
    logic [3:0] ready;
    logic [2:0] n_off;

    typedef struct {
        logic [3:0] cg;
        logic [3:0] rdy;
        logic [2:0] noff;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Contention tables: rr_ptr=0 and rr_ptr=2 starts, all four domains OFF, req held at 4'hF.
    logic [3:0] rr0_cg  [6] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF};
    logic [3:0] rr0_rdy [6] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    logic [2:0] rr_n    [6] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    logic [3:0] rr2_cg  [6] = '{4'h4, 4'hC, 4'hD, 4'hF, 4'hF, 4'hF};
    logic [3:0] rr2_rdy [6] = '{4'h0, 4'h0, 4'h4, 4'hC, 4'hD, 4'hF};
    // Bypass with d1,d3 OFF and d2 counting idle, rr_ptr=0.
    logic [3:0] byp_cg  [4] = '{4'h7, 4'hF, 4'hF, 4'hF};
    logic [3:0] byp_rdy [4] = '{4'h5, 4'h5, 4'h7, 4'hF};
    logic [2:0] byp_n   [4] = '{3'd1, 3'd0, 3'd0, 3'd0};

    iiitb_cg_ctrl #(.N_DOM(4), .IDLE_CYC(8), .WAKE_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .req       (req),
        .cg_bypass (cg_bypass),
        .cg_en     (cg_en),
        .ready     (ready),
        .n_off     (n_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [3:0] b, input logic [3:0] q, input logic byp,
                        input logic [3:0] ecg, input logic [3:0] erdy, input logic [2:0] en,
                        input string tag);
        exp_t e;
        rst       = r;
        busy      = b;
        req       = q;
        cg_bypass = byp;
        @(posedge clk);
        #1;
        e.cg   = ecg;
        e.rdy  = erdy;
        e.noff = en;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // n edges with fixed inputs; outputs hold "pre" values until the n-th edge gives "post".
    task automatic run_n(input int n, input logic [3:0] b, input logic [3:0] q, input logic byp,
                         input logic [3:0] cg_pre, input logic [3:0] rdy_pre, input logic [2:0] n_pre,
                         input logic [3:0] cg_post, input logic [3:0] rdy_post, input logic [2:0] n_post,
                         input string tag);
        for (int k = 1; k <= n; k++) begin
            if (k == n) step(1'b0, b, q, byp, cg_post, rdy_post, n_post, tag);
            else        step(1'b0, b, q, byp, cg_pre, rdy_pre, n_pre, tag);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (cg_en !== mon_e.cg || ready !== mon_e.rdy || n_off !== mon_e.noff) begin
                errors++;
                $display("FAIL %s: got cg_en=%h ready=%h n_off=%0d, want cg_en=%h ready=%h n_off=%0d",
                         mon_e.tag, cg_en, ready, n_off, mon_e.cg, mon_e.rdy, mon_e.noff);
            end else begin
                $display("[%0t] %s: cg_en=%h ready=%h n_off=%0d ok",
                         $time, mon_e.tag, cg_en, ready, n_off);
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; busy = '0; req = '0; cg_bypass = 1'b0;

        // Reset with random activity, then release with all domains busy.
        step(1'b1, 4'($urandom), 4'($urandom), 1'b0, 4'hF, 4'hF, 3'd0, "reset");
        step(1'b1, 4'($urandom), 4'($urandom), 1'b0, 4'hF, 4'hF, 3'd0, "reset");
        for (int k = 0; k < 3; k++) step(1'b0, 4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, "release");

        // Domain 0 idle for 8 edges gates.
        run_n(8, 4'hE, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, 4'hE, 4'hE, 3'd1, "idle_gate");

        // Single wake then re-gate after 8 idle edges.
        step(1'b0, 4'hE, 4'h1, 1'b0, 4'hF, 4'hE, 3'd0, "wake_grant");
        step(1'b0, 4'hE, 4'h0, 1'b0, 4'hF, 4'hE, 3'd0, "wake_hold");
        step(1'b0, 4'hE, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, "wake_ready");
        run_n(8, 4'hE, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, 4'hE, 4'hE, 3'd1, "regate");

        // Busy pulse on the 5th idle edge restarts the count: gating after edge 13.
        step(1'b0, 4'hE, 4'h1, 1'b0, 4'hF, 4'hE, 3'd0, "wake_grant2");
        step(1'b0, 4'hE, 4'h0, 1'b0, 4'hF, 4'hE, 3'd0, "wake_hold2");
        step(1'b0, 4'hE, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, "wake_ready2");
        for (int k = 1; k <= 13; k++)
            step(1'b0, (k == 5) ? 4'hF : 4'hE, 4'h0, 1'b0,
                 (k == 13) ? 4'hE : 4'hF, (k == 13) ? 4'hE : 4'hF, (k == 13) ? 3'd1 : 3'd0, "restart");

        // All gate; wake d2 then reset while d2 is in WAKE and d0 is OFF.
        run_n(8, 4'h0, 4'h0, 1'b0, 4'hE, 4'hE, 3'd1, 4'h0, 4'h0, 3'd4, "gate_rest");
        step(1'b0, 4'h0, 4'h4, 1'b0, 4'h4, 4'h0, 3'd3, "wake_d2");
        step(1'b1, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, "reset_mid");

        // Contention from rr_ptr=0 (also proves reset cleared the pointer).
        run_n(8, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, 4'h0, 4'h0, 3'd4, "gate_all");
        for (int k = 0; k < 6; k++)
            step(1'b0, 4'h0, 4'hF, 1'b0, rr0_cg[k], rr0_rdy[k], rr_n[k], "rr0");

        // Move rr_ptr to 2 by waking d1 alone, re-gate, then contend again.
        run_n(8, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, 4'h0, 4'h0, 3'd4, "gate_all2");
        step(1'b0, 4'h0, 4'h2, 1'b0, 4'h2, 4'h0, 3'd3, "wake_d1");
        step(1'b0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h0, 3'd3, "wake_d1_hold");
        step(1'b0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h2, 3'd3, "wake_d1_ready");
        run_n(8, 4'h0, 4'h0, 1'b0, 4'h2, 4'h2, 3'd3, 4'h0, 4'h0, 3'd4, "regate_d1");
        for (int k = 0; k < 6; k++)
            step(1'b0, 4'h0, 4'hF, 1'b0, rr2_cg[k], rr2_rdy[k], rr_n[k], "rr2");

        // Bypass: d1,d3 OFF, d2 mid-count.
        step(1'b1, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, "reset2");
        run_n(8, 4'h5, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, 4'h5, 4'h5, 3'd2, "gate_d1d3");
        run_n(3, 4'h1, 4'h0, 1'b0, 4'h5, 4'h5, 3'd2, 4'h5, 4'h5, 3'd2, "idle_d2");
        for (int k = 0; k < 4; k++)
            step(1'b0, 4'h1, 4'h0, 1'b1, byp_cg[k], byp_rdy[k], byp_n[k], "bypass_wake");
        run_n(10, 4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 3'd0, 4'hF, 4'hF, 3'd0, "bypass_hold");

        // After release: busy on the expiring edge keeps domains on, then 8 idle edges gate.
        run_n(7, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, 4'hF, 4'hF, 3'd0, "post_bypass");
        step(1'b0, 4'hF, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, "late_busy");
        run_n(8, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 3'd0, 4'h0, 4'h0, 3'd4, "regate_all");

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
